// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multicycle MIPS controller and datapath
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mdr_write, a_write, b_write, alu_out_write,
               reg_write, mem_read, mem_write, iord, alu_src_a, alu_src_b,
               alu_op, pc_source, reg_dst, mem_to_reg, retire, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mdr_write, a_write, b_write, alu_out_write,
               reg_write, mem_read, mem_write, iord, alu_src_a, alu_src_b,
               alu_op, pc_source, reg_dst, mem_to_reg, retire, illegal, state
    );
endinterface

// File: rtl/multicycle_control_ctrl_out_decode.sv
// rtl/multicycle_control_ctrl_out_decode.sv - combinational state-to-control decoder
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       active,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        // active low forces every strobe off, including the FETCH read
        if (active) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b     = SRCB_IMM_SH2;
                    ctrl.a_write       = 1'b1;
                    ctrl.b_write       = 1'b1;
                    ctrl.alu_out_write = 1'b1;
                    ctrl.illegal       = !is_legal_op(opcode);
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_IMM;
                    ctrl.alu_out_write = 1'b1;
                end
                S_MEM_READ: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.iord      = 1'b1;
                    ctrl.mdr_write = mem_ready;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.retire     = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                    ctrl.retire    = mem_ready;
                end
                S_EXEC: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALU_FUNCT;
                    ctrl.alu_out_write = 1'b1;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_source = PCSRC_ALUOUT;
                    ctrl.pc_write  = zero;
                    ctrl.retire    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.pc_write  = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencer for the multicycle MIPS datapath
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            // IR still holds the opcode here, so it picks load vs store
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC:      state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state     (state_q),
        .active    (rst),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mdr_write     = ctrl.mdr_write;
    assign bus.a_write       = ctrl.a_write;
    assign bus.b_write       = ctrl.b_write;
    assign bus.alu_out_write = ctrl.alu_out_write;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.iord          = ctrl.iord;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.retire        = ctrl.retire;
    assign bus.illegal       = ctrl.illegal;
    assign bus.state         = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencer for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback, driving every datapath register write enable (PC, IR, MDR, A, B, ALUOut), the register-file write, the memory strobes and all mux selects. It stalls on a memory ready handshake and sits between the instruction/data memory and the shared datapath registers.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  in  1  rising-edge clock; the design uses one clock.
- rst  in  1  reset, asynchronous and active-low.
- opcode  in  6  IR[31:26], sampled in DECODE.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write, ir_write, mdr_write, a_write, b_write, alu_out_write  out  1 each  register write enables.
- reg_write  out  1  register-file write enable.
- mem_read, mem_write  out  1 each  memory strobes.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- reg_dst  out  1  register-file destination: 0 = rt, 1 = rd.
- mem_to_reg  out  1  register-file write data: 0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse in the final cycle of each legal instruction.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state  out  4  current state, for debug.

## Operation
- Supported opcodes:
  - R-type: 000000.
  - lw: 100011.
  - sw: 101011.
  - beq: 000100.
  - j: 000010.
  - addi: 001000.
- Any output not listed for a state is 0.
- State behaviour, with outputs and next state:
  - FETCH (0): mem_read=1, iord=0, alu_src_b=01, alu_op=00. When mem_ready=1, ir_write=1 and pc_write=1, then go to DECODE. Otherwise hold in FETCH with both enables at 0.
  - DECODE (1): alu_src_b=11, a_write=1, b_write=1, alu_out_write=1 (this precomputes the branch target). Next state by opcode: lw/sw go to MEM_ADDR, R-type to EXEC, beq to BRANCH, j to JUMP, addi to ADDI_EXEC. Any other opcode pulses illegal and returns to FETCH.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_out_write=1. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ (3): mem_read=1, iord=1, mdr_write=mem_ready. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next is FETCH.
  - MEM_WRITE (5): mem_write=1, iord=1. When mem_ready=1, retire=1 and go to FETCH; otherwise hold.
  - EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10, alu_out_write=1. Next is R_WB.
  - R_WB (7): reg_write=1, reg_dst=1, retire=1. Next is FETCH.
  - BRANCH (8): alu_src_a=1, alu_op=01, pc_source=01, pc_write=zero, retire=1. Next is FETCH.
  - JUMP (9): pc_source=10, pc_write=1, retire=1. Next is FETCH.
  - ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, alu_out_write=1. Next is ADDI_WB.
  - ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next is FETCH.
- State codes 12–15 are unreachable. If entered, go to FETCH on the next edge with all outputs 0.

## Timing
- Only the state register is sequential. All outputs decode combinationally from the state and the current-cycle inputs (mem_ready, zero, opcode).
- Cycles per instruction with mem_ready held high:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Illegal opcode: 2.
- Each memory-state cycle with mem_ready=0 adds one cycle. No enable or retire fires while stalled.
- Reset:
  - While rst=0, state=FETCH and every output is forced to 0, including mem_read.
  - Assertion is asynchronous and takes effect mid-instruction with no completion.
  - After release, the first FETCH cycle is at the next rising edge.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- In BRANCH, zero is sampled combinationally in the same cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - State encodings.
  - Opcode constants.
  - alu_op, alu_src_b and pc_source encodings.
  - The ALU and datapath blocks import these same encodings.
- Optional sub-module ctrl_out_decode: a purely combinational state-to-outputs decoder, kept separate from the next-state logic.

## Test plan
- Reset held with opcode=100011 → all outputs 0, state=0. After release with mem_ready=1, mem_read=1 and ir_write=1 in cycle 1.
- lw (100011) with mem_ready=1 → state sequence 0,1,2,3,4. mdr_write in cycle 4. reg_write=1, mem_to_reg=1 and retire in cycle 5.
- sw with mem_ready low for 3 cycles in MEM_WRITE → mem_write held high for 4 cycles, retire once, total 7 cycles.
- beq with zero=1 → pc_write=1, pc_source=01 in cycle 3. With zero=0 → pc_write=0, retire still 1.
- opcode 111111 → illegal pulse in DECODE, next state FETCH, no retire.
- rst dropped during MEM_READ → outputs 0 immediately. Fetch restarts after release and mdr_write never fires.
